// File: rtl/rv32i_types.sv
// rv32i_types: shared store/branch packet types for the post-store queue.
package rv32i_types;
  localparam int NUM_BR = 4;
  localparam int BR_W = $clog2(NUM_BR);
  typedef struct packed {
    logic cdb_broadcast;
    logic br_mispred;
    logic [BR_W-1:0] br_tag;
  } cdb_pkt_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] wmask;
    logic [NUM_BR-1:0] bmask;
  } mem_pkt_t;
endpackage

// File: rtl/post_st_fwd_search.sv
// post_st_fwd_search: head-relative priority search returning youngest or oldest match offset.
module post_st_fwd_search #(
  parameter int DEPTH = 8,
  parameter bit YOUNGEST = 1'b1
) (
  input  logic [DEPTH-1:0]         match,
  input  logic [$clog2(DEPTH)-1:0] head,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] off
);
  localparam int IW = $clog2(DEPTH);
  always_comb begin
    found = 1'b0;
    off = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[head + IW'(k)] && (YOUNGEST || !found)) begin
        found = 1'b1;
        off = IW'(k);
      end
    end
  end
endmodule

// File: rtl/post_st_queue.sv
// post_st_queue: multi-port speculative in-order store queue with load forwarding check.
module post_st_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 8,
  parameter int WR_PORTS = 2,
  parameter int NUM_BR = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  cdb_pkt_t                 cdb_pkt2,
  input  logic [WR_PORTS-1:0]      wen,
  input  mem_pkt_t                 fifo_in [WR_PORTS],
  output logic [WR_PORTS-1:0]      wr_accept,
  output logic [$clog2(DEPTH):0]   wr_free,
  input  logic                     ren,
  output logic                     head_safe,
  output mem_pkt_t                 fifo_out,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     ld_chk_valid,
  input  logic [31:0]              ld_chk_addr,
  input  logic [3:0]               ld_chk_mask,
  output logic                     ld_hit,
  output logic                     ld_fwd_ok,
  output logic [31:0]              ld_fwd_data,
  output logic                     ld_conflict
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  if (NUM_BR != rv32i_types::NUM_BR) begin : g_nbr
    $error("post_st_queue NUM_BR does not match rv32i_types");
  end
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, n_acc;
  mem_pkt_t mem_q [DEPTH];
  mem_pkt_t mem_d [DEPTH];
  mem_pkt_t pkt, head_pkt, ld_pkt;
  logic [DEPTH-1:0] valid, ld_match, sq_match;
  logic [IW-1:0] head_idx, ld_off, sq_off;
  logic ld_found, sq_found, resolve, mispred, head_sq, pop;
  assign head_idx = head_q[IW-1:0];
  assign count = tail_q - head_q;
  assign wr_free = PW'(DEPTH) - count;
  assign fifo_empty = head_q == tail_q;
  assign fifo_full = (head_q[IW] != tail_q[IW]) && (head_idx == tail_q[IW-1:0]);
  assign resolve = cdb_pkt2.cdb_broadcast && !cdb_pkt2.br_mispred;
  assign mispred = cdb_pkt2.cdb_broadcast && cdb_pkt2.br_mispred;
  assign head_pkt = mem_q[head_idx];
  assign fifo_out = head_pkt;
  // A mispredict that squashes the head must block the pop in the same cycle.
  assign head_sq = mispred && sq_found && sq_off == '0;
  assign head_safe = !fifo_empty && head_pkt.bmask == '0 && !head_sq;
  assign pop = ren && head_safe;
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      valid[j] = {1'b0, IW'(j) - head_idx} < count;
      sq_match[j] = valid[j] && mem_q[j].bmask[cdb_pkt2.br_tag];
      ld_match[j] = valid[j] && mem_q[j].addr[31:2] == ld_chk_addr[31:2];
    end
  end
  post_st_fwd_search #(.DEPTH(DEPTH), .YOUNGEST(1'b1)) u_ld_search (
    .match(ld_match),
    .head(head_idx),
    .found(ld_found),
    .off(ld_off)
  );
  post_st_fwd_search #(.DEPTH(DEPTH), .YOUNGEST(1'b0)) u_sq_search (
    .match(sq_match),
    .head(head_idx),
    .found(sq_found),
    .off(sq_off)
  );
  assign ld_pkt = mem_q[head_idx + ld_off];
  assign ld_hit = ld_chk_valid && ld_found;
  assign ld_fwd_ok = ld_hit && (ld_pkt.wmask & ld_chk_mask) == ld_chk_mask;
  assign ld_fwd_data = ld_hit ? ld_pkt.wdata : 32'h0;
  assign ld_conflict = ld_hit && !ld_fwd_ok;
  always_comb begin
    n_acc = '0;
    pkt = fifo_in[0];
    mem_d = mem_q;
    for (int j = 0; j < DEPTH; j++) begin
      if (resolve) mem_d[j].bmask[cdb_pkt2.br_tag] = 1'b0;
    end
    for (int i = 0; i < WR_PORTS; i++) begin
      wr_accept[i] = wen[i] && !mispred && wr_free > n_acc;
      pkt = fifo_in[i];
      if (resolve) pkt.bmask[cdb_pkt2.br_tag] = 1'b0;
      if (wr_accept[i]) mem_d[IW'(tail_q + n_acc)] = pkt;
      n_acc = n_acc + PW'(wr_accept[i]);
    end
    tail_d = mispred ? (sq_found ? head_q + PW'(sq_off) : tail_q) : tail_q + n_acc;
    head_d = head_q + PW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      mem_q <= mem_d;
    end
  end
  if (WR_PORTS > 1) begin : g_wen_chk
    always_ff @(posedge clk) begin
      if (!rst) assert (!(wen[1] && !wen[0]));
    end
  end
endmodule
